pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_mux.sv | 17 +
 rtl/pc_sequencer.sv | 93 +++++++++
 tb/tb_pc_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: reset/step defaults,
// FSM state encoding and the target alignment helper.
package pc_pkg;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

    typedef enum logic [1:0] {
        StRun  = 2'b00,
        StHalt = 2'b01,
        StTrap = 2'b10
    } pc_state_e;

    // A fetch target must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_mux.sv
// Final PC target selection: taken target or the sequential address.
module pc_mux (
    input  logic [31:0] JUMP,
    input  logic [31:0] NEXT,
    input  logic        BRANCH,
    output logic [31:0] TARGET
);

    // Pick the taken target when a branch is live, else fall through.
    always_comb begin
        TARGET = NEXT;
        if (BRANCH) begin
            TARGET = JUMP;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, branches with a one-entry
// pending target buffer for stalled cycles, halt and misaligned-target trap.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter logic [31:0] PC_STEP      = PC_STEP_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] JUMP,
    input  logic        BRANCH,
    input  logic        STALL,
    input  logic        HALT,
    input  logic        FETCH_READY,
    output logic [31:0] PC,
    output logic [31:0] NEXT,
    output logic        FETCH_VALID,
    output logic        MISALIGNED,
    output logic        HALTED
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_valid_q, pend_valid_d;

    logic [31:0] eff_target;
    logic [31:0] sel_target;
    logic        taken;
    logic        advance;

    // Sequential address wraps naturally at 2^32.
    assign NEXT       = pc_q + PC_STEP;
    // A live BRANCH beats an older pending target.
    assign eff_target = BRANCH ? JUMP : pend_q;
    assign taken      = BRANCH | pend_valid_q;
    assign advance    = (state_q == StRun) & FETCH_READY & ~STALL & ~HALT;

    pc_mux u_pc_mux (
        .JUMP   (eff_target),
        .NEXT   (NEXT),
        .BRANCH (taken),
        .TARGET (sel_target)
    );

    // Next-state logic: HALT first, then the alignment check on advance,
    // otherwise capture any branch that could not be taken this cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (state_q == StRun) begin
            if (HALT) begin
                state_d      = StHalt;
                pend_valid_d = 1'b0;
            end else if (advance) begin
                pend_valid_d = 1'b0;
                if (taken && is_misaligned(sel_target)) begin
                    state_d = StTrap;
                end else begin
                    pc_d = sel_target;
                end
            end else if (BRANCH) begin
                pend_d       = JUMP;
                pend_valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StRun;
            pc_q         <= RESET_VECTOR;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign PC          = pc_q;
    assign FETCH_VALID = (state_q == StRun);
    // TRAP is only left through reset, so the state itself is the sticky flag.
    assign MISALIGNED  = (state_q == StTrap);
    assign HALTED      = (state_q == StHalt);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] jump;
    logic        branch;
    logic        stall;
    logic        halt;
    logic        fetch_ready;
    logic [31:0] pc;
    logic [31:0] next;
    logic        fetch_valid;
    logic        misaligned;
    logic        halted;

    int n_checks;
    int n_fail;

    pc_sequencer dut (
        .CLK         (clk),
        .RST         (rst),
        .JUMP        (jump),
        .BRANCH      (branch),
        .STALL       (stall),
        .HALT        (halt),
        .FETCH_READY (fetch_ready),
        .PC          (pc),
        .NEXT        (next),
        .FETCH_VALID (fetch_valid),
        .MISALIGNED  (misaligned),
        .HALTED      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp_pc, input logic exp_fv,
                                input logic exp_mis, input logic exp_halt);
        check_eq({tag, ".pc"}, pc, exp_pc);
        check_eq({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, exp_fv});
        check_eq({tag, ".mis"}, {31'd0, misaligned}, {31'd0, exp_mis});
        check_eq({tag, ".halted"}, {31'd0, halted}, {31'd0, exp_halt});
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        jump        = '0;
        branch      = 1'b0;
        stall       = 1'b0;
        halt        = 1'b0;
        fetch_ready = 1'b0;
        #1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_status("reset", 32'h0, 1'b1, 1'b0, 1'b0);
        check_eq("reset.next", next, 32'h4);

        // Sequential fetch
        fetch_ready = 1'b1;
        step(); check_eq("seq1", pc, 32'h4);
        step(); check_eq("seq2", pc, 32'h8);
        step(); check_eq("seq3", pc, 32'hC);

        // FETCH_READY low holds PC at 0x8 with FETCH_VALID high
        do_reset();
        step(); step();
        check_eq("fr_pre", pc, 32'h8);
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_status("fr_hold", 32'h8, 1'b1, 1'b0, 1'b0);
        end

        // Branch under stall becomes pending, taken on release
        fetch_ready = 1'b1;
        step(); step();
        check_eq("pre_stall", pc, 32'h10);
        branch = 1'b1; jump = 32'h100; stall = 1'b1;
        step(); check_status("stall1", 32'h10, 1'b1, 1'b0, 1'b0);
        step(); check_status("stall2", 32'h10, 1'b1, 1'b0, 1'b0);
        branch = 1'b0; stall = 1'b0; jump = 32'h0;
        step(); check_eq("pend_taken", pc, 32'h100);
        step(); check_eq("after_pend", pc, 32'h104);

        // Later branch overwrites pending target
        stall = 1'b1; branch = 1'b1; jump = 32'h200;
        step();
        jump = 32'h300;
        step();
        branch = 1'b0; stall = 1'b0;
        step(); check_eq("pend_overwrite", pc, 32'h300);

        // Direct branch then misaligned direct branch traps
        branch = 1'b1; jump = 32'h20;
        step(); check_eq("direct_br", pc, 32'h20);
        jump = 32'h202;
        step(); check_status("trap", 32'h20, 1'b0, 1'b1, 1'b0);
        jump = 32'h40;
        step(); check_status("trap_sticky", 32'h20, 1'b0, 1'b1, 1'b0);
        branch = 1'b0;
        do_reset();
        check_status("trap_rst", 32'h0, 1'b1, 1'b0, 1'b0);

        // Misaligned pending target traps only when consumed
        stall = 1'b1; branch = 1'b1; jump = 32'h303;
        step(); check_status("pend_mis_latch", 32'h0, 1'b1, 1'b0, 1'b0);
        branch = 1'b0; stall = 1'b0;
        step(); check_status("pend_mis_trap", 32'h0, 1'b0, 1'b1, 1'b0);
        do_reset();

        // Wrap at top of address space
        branch = 1'b1; jump = 32'hFFFF_FFFC;
        step(); check_eq("wrap_pre", pc, 32'hFFFF_FFFC);
        check_eq("wrap_next", next, 32'h0);
        branch = 1'b0;
        step(); check_eq("wrap", pc, 32'h0);

        // HALT beats a same-cycle branch
        step(); check_eq("halt_pre", pc, 32'h4);
        halt = 1'b1; branch = 1'b1; jump = 32'h40;
        step(); check_status("halt", 32'h4, 1'b0, 1'b0, 1'b1);
        halt = 1'b0;
        step(); check_status("halt_stay", 32'h4, 1'b0, 1'b0, 1'b1);
        branch = 1'b0;
        do_reset();
        check_status("halt_rst", 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset discards a pending target
        step(); step();
        stall = 1'b1; branch = 1'b1; jump = 32'h500;
        step(); check_eq("rst_pend_pre", pc, 32'h8);
        branch = 1'b0;
        do_reset();
        check_eq("rst_pend_rst", pc, 32'h0);
        stall = 1'b0;
        step(); check_eq("rst_pend_drop", pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
